stream_encryptor: RTL and testbench
===================================

STREAM_ENCRYPTOR -- requirements
Module: stream_encryptor

Interface
REQ-001 Parameter FALLBACK_SEED, default 16'hACE1, seed substituted whenever the LFSR would be loaded with or become zero.
REQ-002 Parameter TAPS, default 16'hB400, Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1).
REQ-003 Ports: one clock; reset is asynchronous and active-low; named as below.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 nrst  input  1  asynchronous active-low reset.
REQ-006 key_in  input  16  key/seed value.
REQ-007 key_load  input  1  one-cycle pulse; load key_in.
REQ-008 data_in  input  8  plaintext byte.
REQ-009 data_in_pulse  input  1  one-cycle pulse; data_in valid.
REQ-010 enc_data  output  8  ciphertext byte, feeds output_holder data_in.
REQ-011 enc_pulse  output  1  one-cycle pulse, feeds output_holder data_in_pulse.
REQ-012 cipher_state_out  output  cipher_state_t  current FSM state, to interface FSM.
REQ-013 overrun  output  1  sticky; plaintext dropped while BUSY.

Function
REQ-014 FSM states SHALL be UNKEYED, READY, BUSY.
REQ-015 key_load in any state SHALL load LFSR with key_in (FALLBACK_SEED if key_in==0), clear overrun, clear step counter, and enter READY next edge; an in-flight byte is aborted with no enc_pulse.
REQ-016 key_load and data_in_pulse in the same cycle: key wins, byte discarded, overrun not set.
REQ-017 data_in_pulse in UNKEYED SHALL be ignored, no flag.
REQ-018 data_in_pulse in READY at edge E0 SHALL latch data_in, clear 3-bit step counter, enter BUSY.
REQ-019 Each BUSY edge E1..E8 SHALL perform one LFSR step: out bit = s[0]; s = (s>>1) ^ (s[0] ? TAPS : 0); out bit k (step k+1) forms keystream bit k (LSB first).
REQ-020 At E8, enc_data SHALL be registered as latched byte XOR keystream byte, enc_pulse SHALL be high for the single cycle E8..E9, state returns READY.
REQ-021 Latency accept-edge to enc_pulse-rise SHALL be exactly 8 cycles; throughput one byte per 8 cycles; a new data_in_pulse during the enc_pulse cycle SHALL be accepted.
REQ-022 data_in_pulse in BUSY SHALL be dropped and set overrun; the in-flight byte completes unaffected.
REQ-023 enc_data SHALL hold its last value between pulses.
REQ-024 If a step or feedback would produce s==0, s SHALL become FALLBACK_SEED instead.

Reset
REQ-025 nrst low SHALL asynchronously force: state UNKEYED, LFSR 16'h0000 (invalid until keyed), counter 0, enc_data 8'h00, enc_pulse 0, overrun 0.
REQ-026 Reset during BUSY SHALL abort with no enc_pulse after release; a key_load is required before encryption resumes.

Configuration
REQ-027 Macro STREAM_CIPHER_CT_FEEDBACK_EN defined: at E8, after the 8th step, s[7:0] SHALL be XORed with the produced ciphertext byte (zero rule REQ-024 applies).
REQ-028 Macro undefined: LFSR evolves from key only; no feedback logic present.

Structure
REQ-029 cipher_state_t and FALLBACK_SEED/TAPS defaults SHALL live in the shared stream_cipher package beside interface_state_t and output_holder_state_t.
REQ-030 LFSR step plus zero-substitution SHALL be a sub-module keystream_lfsr (load, step, feedback-xor inputs; state output).

Verification
REQ-031 Key 16'h0001, plaintext 8'h41 -> enc_data 8'h40, enc_pulse 8 cycles after accept, LFSR 16'h0168.
REQ-032 Continuing, plaintext 8'h00 (feedback undefined) -> enc_data 8'h68, LFSR 16'h7C41.
REQ-033 Key 16'h0000 -> LFSR loaded 16'hACE1; data_in_pulse while UNKEYED after reset -> no enc_pulse, overrun 0.
REQ-034 Key 16'h0001, pulse 8'h41, second pulse 3 cycles later -> single enc_pulse 8'h40, overrun 1; key_load -> overrun 0.
REQ-035 key_load 4 cycles into BUSY -> no enc_pulse, state READY, LFSR == new key.
REQ-036 nrst asserted mid-BUSY -> all outputs reset values immediately, state UNKEYED, no pulse after release.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// ---------------------------------------------------------------------------
// stream_cipher_pkg
// Shared types and constants for the stream cipher datapath: the encryptor
// FSM state type, the neighbouring interface / output-holder FSM state types,
// LFSR defaults and the Galois LFSR step helper.
// ---------------------------------------------------------------------------
package stream_cipher_pkg;

    localparam int unsigned LFSR_W     = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned STEP_CNT_W = 3;

    // Seed used whenever the LFSR would otherwise hold the all-zero lock-up state
    localparam logic [LFSR_W-1:0] FALLBACK_SEED_DEFAULT = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Galois (right-shifting) form
    localparam logic [LFSR_W-1:0] TAPS_DEFAULT          = 16'hB400;

    typedef enum logic [1:0] {
        CS_UNKEYED = 2'd0,
        CS_READY   = 2'd1,
        CS_BUSY    = 2'd2
    } cipher_state_t;

    typedef enum logic [1:0] {
        IF_IDLE      = 2'd0,
        IF_KEYING    = 2'd1,
        IF_STREAMING = 2'd2
    } interface_state_t;

    typedef enum logic [0:0] {
        OH_EMPTY = 1'b0,
        OH_FULL  = 1'b1
    } output_holder_state_t;

    // One raw Galois step; zero substitution is the caller's job
    function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] s,
                                                      input logic [LFSR_W-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : {LFSR_W{1'b0}});
    endfunction

endpackage : stream_cipher_pkg

// File: rtl/keystream_lfsr.sv
// ---------------------------------------------------------------------------
// keystream_lfsr
// 16-bit Galois LFSR holding the cipher state. A load has priority over a
// step; a step may additionally XOR a byte into the low bits (ciphertext
// feedback). Any load/step result of zero is replaced by FALLBACK_SEED.
// Ports:
//   clk, nrst      clock, async active-low reset (state resets to zero)
//   load_i         load load_val_i this edge
//   load_val_i     value to load
//   step_i         advance one Galois step this edge
//   fb_i           byte XORed into state[7:0] after the step
//   state_o        current LFSR state (bit 0 is the next keystream bit)
// ---------------------------------------------------------------------------
module keystream_lfsr
    import stream_cipher_pkg::*;
#(
    parameter logic [LFSR_W-1:0] FALLBACK_SEED = FALLBACK_SEED_DEFAULT,
    parameter logic [LFSR_W-1:0] TAPS          = TAPS_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              step_i,
    input  logic [BYTE_W-1:0] fb_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next state: load beats step; only freshly produced values are zero-checked
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (step_i) begin
            state_d = galois_step(state_q, TAPS) ^ {{(LFSR_W-BYTE_W){1'b0}}, fb_i};
        end
        if ((load_i || step_i) && (state_d == {LFSR_W{1'b0}})) begin
            state_d = FALLBACK_SEED;
        end
    end

    // Zero after reset marks the LFSR as unkeyed
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= {LFSR_W{1'b0}};
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule : keystream_lfsr

// File: rtl/stream_encryptor.sv
// ---------------------------------------------------------------------------
// stream_encryptor
// Byte-serial stream cipher. A key loads a Galois LFSR; each accepted
// plaintext byte is XORed with 8 keystream bits (one LFSR step per cycle,
// LSB first) and emitted 8 cycles after acceptance with a one-cycle pulse.
// Plaintext arriving while a byte is in flight is dropped and flagged in the
// sticky overrun bit; a key load always wins and aborts any in-flight byte.
// Ports:
//   clk, nrst         clock, async active-low reset
//   key_in/key_load   key value and its load pulse
//   data_in/_pulse    plaintext byte and its valid pulse
//   enc_data          ciphertext byte (held between pulses)
//   enc_pulse         one-cycle ciphertext valid
//   cipher_state_out  current FSM state
//   overrun           sticky dropped-plaintext flag
// Build option: define STREAM_CIPHER_CT_FEEDBACK_EN to XOR each ciphertext
// byte back into the LFSR low byte after its 8th step.
// ---------------------------------------------------------------------------
module stream_encryptor
    import stream_cipher_pkg::*;
#(
    parameter logic [LFSR_W-1:0] FALLBACK_SEED = FALLBACK_SEED_DEFAULT,
    parameter logic [LFSR_W-1:0] TAPS          = TAPS_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [LFSR_W-1:0] key_in,
    input  logic              key_load,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_in_pulse,
    output logic [BYTE_W-1:0] enc_data,
    output logic              enc_pulse,
    output cipher_state_t     cipher_state_out,
    output logic              overrun
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(BYTE_W - 1);

    cipher_state_t           state_q, state_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [STEP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-2:0]       ks_q, ks_d;
    logic [BYTE_W-1:0]       enc_data_q, enc_data_d;
    logic                    enc_pulse_q, enc_pulse_d;
    logic                    overrun_q, overrun_d;

    logic                    lfsr_load;
    logic                    lfsr_step;
    logic [BYTE_W-1:0]       lfsr_fb;
    logic [LFSR_W-1:0]       lfsr_state;
    logic [BYTE_W-1:0]       ct_c;

    // Only bit 0 feeds the datapath; the rest is kept for visibility
    logic                    unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:1];

    // Ciphertext for the last step: 7 stored keystream bits plus the live 8th
    assign ct_c = byte_q ^ {lfsr_state[0], ks_q};

    keystream_lfsr #(
        .FALLBACK_SEED (FALLBACK_SEED),
        .TAPS          (TAPS)
    ) u_lfsr (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (lfsr_load),
        .load_val_i (key_in),
        .step_i     (lfsr_step),
        .fb_i       (lfsr_fb),
        .state_o    (lfsr_state)
    );

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        ks_d        = ks_q;
        enc_data_d  = enc_data_q;
        enc_pulse_d = 1'b0;
        overrun_d   = overrun_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        lfsr_fb     = {BYTE_W{1'b0}};

        if (key_load) begin
            // Key load overrides everything, including a same-cycle byte
            lfsr_load = 1'b1;
            overrun_d = 1'b0;
            cnt_d     = {STEP_CNT_W{1'b0}};
            state_d   = CS_READY;
        end else begin
            unique case (state_q)
                CS_UNKEYED: begin
                end
                CS_READY: begin
                    if (data_in_pulse) begin
                        byte_d  = data_in;
                        cnt_d   = {STEP_CNT_W{1'b0}};
                        state_d = CS_BUSY;
                    end
                end
                CS_BUSY: begin
                    lfsr_step = 1'b1;
                    ks_d      = {lfsr_state[0], ks_q[BYTE_W-2:1]};
                    cnt_d     = cnt_q + STEP_CNT_W'(1);
                    if (data_in_pulse) begin
                        overrun_d = 1'b1;
                    end
                    if (cnt_q == LAST_STEP) begin
                        enc_data_d  = ct_c;
                        enc_pulse_d = 1'b1;
                        state_d     = CS_READY;
`ifdef STREAM_CIPHER_CT_FEEDBACK_EN
                        lfsr_fb     = ct_c;
`endif
                    end
                end
                default: begin
                    state_d = CS_UNKEYED;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= CS_UNKEYED;
            byte_q      <= {BYTE_W{1'b0}};
            cnt_q       <= {STEP_CNT_W{1'b0}};
            ks_q        <= {(BYTE_W-1){1'b0}};
            enc_data_q  <= {BYTE_W{1'b0}};
            enc_pulse_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            ks_q        <= ks_d;
            enc_data_q  <= enc_data_d;
            enc_pulse_q <= enc_pulse_d;
            overrun_q   <= overrun_d;
        end
    end

    assign enc_data         = enc_data_q;
    assign enc_pulse        = enc_pulse_q;
    assign cipher_state_out = state_q;
    assign overrun          = overrun_q;

endmodule : stream_encryptor

// File: tb/tb_stream_encryptor.sv
// ---------------------------------------------------------------------------
// tb_stream_encryptor
// Self-checking bench for stream_encryptor with a byte-level cipher model.
// ---------------------------------------------------------------------------
module tb_stream_encryptor;
    import stream_cipher_pkg::*;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [15:0]   key_in = 16'h0;
    logic          key_load = 1'b0;
    logic [7:0]    data_in = 8'h0;
    logic          data_in_pulse = 1'b0;
    logic [7:0]    enc_data;
    logic          enc_pulse;
    cipher_state_t cipher_state_out;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] m_s;   // model LFSR state

    always #5 clk = ~clk;

    stream_encryptor dut (
        .clk              (clk),
        .nrst             (nrst),
        .key_in           (key_in),
        .key_load         (key_load),
        .data_in          (data_in),
        .data_in_pulse    (data_in_pulse),
        .enc_data         (enc_data),
        .enc_pulse        (enc_pulse),
        .cipher_state_out (cipher_state_out),
        .overrun          (overrun)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_key(input logic [15:0] k);
        return (k == 16'h0) ? FALLBACK_SEED_DEFAULT : k;
    endfunction

    // Encrypt one byte: 8 keystream bits taken LSB first from the LFSR
    task automatic m_encrypt(input logic [7:0] pt, output logic [7:0] ct);
        logic [7:0]  ks;
        logic [15:0] n;
        for (int k = 0; k < 8; k++) begin
            ks[k] = m_s[0];
            n = m_s[0] ? ((m_s >> 1) ^ TAPS_DEFAULT) : (m_s >> 1);
            if (k < 7 && n == 16'h0) n = FALLBACK_SEED_DEFAULT;
            m_s = n;
        end
        ct = pt ^ ks;
`ifdef STREAM_CIPHER_CT_FEEDBACK_EN
        m_s[7:0] = m_s[7:0] ^ ct;
`endif
        if (m_s == 16'h0) m_s = FALLBACK_SEED_DEFAULT;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [15:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        data_in       = b;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
    endtask

    // Cycles until enc_pulse is seen; -1 if the bound expires
    task automatic wait_pulse(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (enc_pulse) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (enc_pulse) pulses++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        tick(); tick();
        n_cmp++; if (cipher_state_out !== CS_UNKEYED) begin n_err++; $display("FAIL reset_state: got %0d want %0d", cipher_state_out, CS_UNKEYED); end
        n_cmp++; if (enc_data !== 8'h00) begin n_err++; $display("FAIL reset_enc_data: got %h want 00", enc_data); end
        n_cmp++; if (enc_pulse !== 1'b0) begin n_err++; $display("FAIL reset_enc_pulse: got %b want 0", enc_pulse); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (dut.lfsr_state !== 16'h0000) begin n_err++; $display("FAIL reset_lfsr: got %h want 0000", dut.lfsr_state); end
        @(negedge clk) nrst = 1'b1;
        tick();
    endtask

    task automatic test_known_vectors();
        int cyc;
        logic [7:0] exp_ct;
        load_key(16'h0001);
        m_s = m_key(16'h0001);
        send(8'h41);
        m_encrypt(8'h41, exp_ct);
        wait_pulse(cyc);
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL kv1_latency: got %0d want 8", cyc); end
        n_cmp++; if (enc_data !== exp_ct) begin n_err++; $display("FAIL kv1_data: got %h want %h", enc_data, exp_ct); end
        n_cmp++; if (dut.lfsr_state !== m_s) begin n_err++; $display("FAIL kv1_lfsr: got %h want %h", dut.lfsr_state, m_s); end
        // Issued during the enc_pulse cycle: must be accepted
        send(8'h00);
        m_encrypt(8'h00, exp_ct);
        wait_pulse(cyc);
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL kv2_latency: got %0d want 8", cyc); end
        n_cmp++; if (enc_data !== exp_ct) begin n_err++; $display("FAIL kv2_data: got %h want %h", enc_data, exp_ct); end
        n_cmp++; if (dut.lfsr_state !== m_s) begin n_err++; $display("FAIL kv2_lfsr: got %h want %h", dut.lfsr_state, m_s); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL kv_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_unkeyed_zero_key();
        int p;
        @(negedge clk) nrst = 1'b0;
        tick();
        @(negedge clk) nrst = 1'b1;
        tick();
        send(8'($urandom));
        watch(12, p);
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL unkeyed_pulses: got %0d want 0", p); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL unkeyed_overrun: got %b want 0", overrun); end
        n_cmp++; if (cipher_state_out !== CS_UNKEYED) begin n_err++; $display("FAIL unkeyed_state: got %0d want %0d", cipher_state_out, CS_UNKEYED); end
        load_key(16'h0000);
        n_cmp++; if (dut.lfsr_state !== 16'hACE1) begin n_err++; $display("FAIL zero_key_lfsr: got %h want ace1", dut.lfsr_state); end
        n_cmp++; if (cipher_state_out !== CS_READY) begin n_err++; $display("FAIL zero_key_state: got %0d want %0d", cipher_state_out, CS_READY); end
    endtask

    task automatic test_overrun();
        int cyc, p;
        logic [7:0] exp_ct;
        load_key(16'h0001);
        m_s = m_key(16'h0001);
        send(8'h41);
        m_encrypt(8'h41, exp_ct);
        tick(); tick();
        send(8'($urandom));   // lands 3 cycles into BUSY
        wait_pulse(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL ovr_latency: got %0d want 5", cyc); end
        n_cmp++; if (enc_data !== exp_ct) begin n_err++; $display("FAIL ovr_data: got %h want %h", enc_data, exp_ct); end
        watch(12, p);
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL ovr_extra_pulses: got %0d want 0", p); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_cmp++; if (enc_data !== exp_ct) begin n_err++; $display("FAIL ovr_hold: got %h want %h", enc_data, exp_ct); end
        load_key(16'($urandom));
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_key_abort();
        int p;
        logic [15:0] nk;
        nk = 16'($urandom_range(1, 65535));
        load_key(16'h0001);
        send(8'($urandom));
        tick(); tick(); tick();
        load_key(nk);          // key arrives 4 cycles into BUSY
        n_cmp++; if (cipher_state_out !== CS_READY) begin n_err++; $display("FAIL abort_state: got %0d want %0d", cipher_state_out, CS_READY); end
        n_cmp++; if (dut.lfsr_state !== nk) begin n_err++; $display("FAIL abort_lfsr: got %h want %h", dut.lfsr_state, nk); end
        watch(12, p);
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL abort_pulses: got %0d want 0", p); end
        // Same-cycle key and data: key wins, byte discarded, no overrun
        key_in = 16'h0001; key_load = 1'b1; data_in = 8'h5A; data_in_pulse = 1'b1;
        tick();
        key_load = 1'b0; data_in_pulse = 1'b0;
        watch(12, p);
        n_cmp++; if (p !== 0 || overrun !== 1'b0) begin n_err++; $display("FAIL key_vs_data: pulses %0d overrun %b want 0 0", p, overrun); end
        n_cmp++; if (dut.lfsr_state !== 16'h0001) begin n_err++; $display("FAIL key_vs_data_lfsr: got %h want 0001", dut.lfsr_state); end
    endtask

    task automatic test_back_to_back();
        int cyc, gap;
        logic [7:0] pt, exp_ct;
        logic [15:0] k;
        k = 16'($urandom);
        load_key(k);
        m_s = m_key(k);
        for (int n = 0; n < 16; n++) begin
            pt = 8'($urandom);
            send(pt);
            m_encrypt(pt, exp_ct);
            wait_pulse(cyc);
            n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 8", n, cyc); end
            n_cmp++; if (enc_data !== exp_ct) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", n, enc_data, exp_ct); end
            n_cmp++; if (dut.lfsr_state !== m_s) begin n_err++; $display("FAIL b2b_lfsr[%0d]: got %h want %h", n, dut.lfsr_state, m_s); end
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) tick();
                n_cmp++; if (enc_pulse !== 1'b0 || enc_data !== exp_ct) begin n_err++; $display("FAIL b2b_hold[%0d]: pulse %b data %h want 0 %h", n, enc_pulse, enc_data, exp_ct); end
            end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_reset_busy();
        int p;
        load_key(16'($urandom));
        send(8'($urandom));
        tick();
        send(8'($urandom));   // sets overrun before the reset hits
        tick();
        nrst = 1'b0;
        #1;
        n_cmp++; if (cipher_state_out !== CS_UNKEYED) begin n_err++; $display("FAIL rstb_state: got %0d want %0d", cipher_state_out, CS_UNKEYED); end
        n_cmp++; if (enc_data !== 8'h00) begin n_err++; $display("FAIL rstb_enc_data: got %h want 00", enc_data); end
        n_cmp++; if (enc_pulse !== 1'b0) begin n_err++; $display("FAIL rstb_enc_pulse: got %b want 0", enc_pulse); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstb_overrun: got %b want 0", overrun); end
        n_cmp++; if (dut.lfsr_state !== 16'h0000) begin n_err++; $display("FAIL rstb_lfsr: got %h want 0000", dut.lfsr_state); end
        @(negedge clk) nrst = 1'b1;
        tick();
        send(8'($urandom));
        watch(12, p);
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL rstb_pulses: got %0d want 0", p); end
        n_cmp++; if (cipher_state_out !== CS_UNKEYED) begin n_err++; $display("FAIL rstb_post_state: got %0d want %0d", cipher_state_out, CS_UNKEYED); end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_unkeyed_zero_key();
        test_overrun();
        test_key_abort();
        test_back_to_back();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule : tb_stream_encryptor
